// File: rtl/regfile_wb_queue_if.sv
// Writeback request channel into regfile_wb_queue: valid/ready with
// destination register and result data.
interface regfile_wb_queue_if #(
  parameter int DW = 64,
  parameter int AW = 5
) ();
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_addr, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_addr, input  in_data, output in_ready);
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO in front of the register file write port.
// Define REGWB_BYPASS_EN to build the newest-pending-data read bypass.
module regfile_wb_queue #(
  parameter int DEPTH    = 4,
  parameter int DW       = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_wb_queue_if.slave        wb,
  input  logic                     drain_en,
  output logic                     RegWrite,
  output logic [AW-1:0]            WriteRegister,
  output logic [DW-1:0]            WriteData,
  input  logic [AW-1:0]            ReadRegister1,
  input  logic [AW-1:0]            ReadRegister2,
  output logic                     byp_hit1,
  output logic [DW-1:0]            byp_data1,
  output logic                     byp_hit2,
  output logic [DW-1:0]            byp_data2,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]  r_head, r_tail;
  logic [CW-1:0]  r_count;
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]  r_addr [DEPTH];
  logic [DW-1:0]  r_data [DEPTH];

  logic w_empty, w_pop, w_push;

  assign w_empty     = (r_count == '0);
  assign wb.in_ready = (r_count != CW'(DEPTH));
  assign w_pop       = !w_empty && drain_en;
  // Zero-register writes are handshaken but never occupy a slot.
  assign w_push      = wb.in_valid && wb.in_ready && (wb.in_addr != AW'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= wb.in_addr;
      r_data[r_tail] <= wb.in_data;
    end
  end

  assign RegWrite      = w_pop;
  assign WriteRegister = w_empty ? '0 : r_addr[r_head];
  assign WriteData     = w_empty ? '0 : r_data[r_head];
  assign occupancy     = r_count;

`ifdef REGWB_BYPASS_EN
  logic [1:0][AW-1:0] w_rd;
  assign w_rd = {ReadRegister2, ReadRegister1};

  for (genvar k = 0; k < 2; k++) begin : g_byp
    logic          hit;
    logic [DW-1:0] dat;
    logic [PW-1:0] idx;
    // Walk oldest to newest so the last match (closest to tail) wins.
    always_comb begin
      hit = 1'b0;
      dat = '0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = r_head + PW'(i);
        if (r_vld[idx] && (r_addr[idx] == w_rd[k]) && (w_rd[k] != AW'(ZERO_REG))) begin
          hit = 1'b1;
          dat = r_data[idx];
        end
      end
    end
  end

  assign byp_hit1  = g_byp[0].hit;
  assign byp_data1 = g_byp[0].dat;
  assign byp_hit2  = g_byp[1].hit;
  assign byp_data2 = g_byp[1].dat;
`else
  assign byp_hit1  = 1'b0;
  assign byp_data1 = '0;
  assign byp_hit2  = 1'b0;
  assign byp_data2 = '0;
`endif
endmodule
